// File: rtl/axi_slave_write_resp_pkg.sv
// Shared widths, AXI encodings and FSM state type for the single-outstanding AXI write slave.
package axi_slave_write_resp_pkg;

    localparam int AXI_IDS_BITS  = 8;
    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_STRB_BITS = 4;
    localparam int AXI_LEN_BITS  = 4;
    localparam int AXI_SIZE_BITS = 3;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Only full-word beats are legal on this 32-bit port
    localparam logic [AXI_SIZE_BITS-1:0] SIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_RESP
    } state_t;

endpackage

// File: rtl/axi_burst_addr.sv
// Burst address generator: word address and beat counter for one write burst.
module axi_burst_addr
    import axi_slave_write_resp_pkg::*;
#(
    parameter int MEM_AW = 14
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    step,
    input  logic [MEM_AW-1:0]       start_addr,
    input  logic [AXI_LEN_BITS-1:0] len,
    input  logic [1:0]              burst,
    output logic [MEM_AW-1:0]       addr,
    output logic                    last
);

    logic [MEM_AW-1:0]       addr_reg;
    logic [AXI_LEN_BITS-1:0] cnt_reg;
    logic [AXI_LEN_BITS-1:0] len_reg;
    logic                    fixed_reg;

    // WRAP and reserved burst types step like INCR; the address wraps at 2^MEM_AW
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg  <= '0;
            cnt_reg   <= '0;
            len_reg   <= '0;
            fixed_reg <= 1'b0;
        end else if (load) begin
            addr_reg  <= start_addr;
            cnt_reg   <= '0;
            len_reg   <= len;
            fixed_reg <= (burst == BURST_FIXED);
        end else if (step) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (!fixed_reg) begin
                addr_reg <= addr_reg + 1'b1;
            end
        end
    end

    assign addr = addr_reg;
    assign last = (cnt_reg == len_reg);

endmodule

// File: rtl/axi_slave_write_resp.sv
// AXI write slave with zero-latency memory write port and one outstanding burst.
// Define AXI_SLV_WR_CHECK_EN to enable SLVERR reporting and write suppression for illegal bursts.
module axi_slave_write_resp
    import axi_slave_write_resp_pkg::*;
#(
    parameter int MEM_AW = 14
)
(
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [AXI_IDS_BITS-1:0]  AWID,
    input  logic [AXI_ADDR_BITS-1:0] AWADDR,
    input  logic [AXI_LEN_BITS-1:0]  AWLEN,
    input  logic [AXI_SIZE_BITS-1:0] AWSIZE,
    input  logic [1:0]               AWBURST,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [AXI_DATA_BITS-1:0] WDATA,
    input  logic [AXI_STRB_BITS-1:0] WSTRB,
    input  logic                     WLAST,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic [AXI_IDS_BITS-1:0]  BID,
    output logic [1:0]               BRESP,
    output logic                     BVALID,
    input  logic                     BREADY,
    output logic [AXI_STRB_BITS-1:0] MEM_WE,
    output logic [MEM_AW-1:0]        MEM_ADDR,
    output logic [AXI_DATA_BITS-1:0] MEM_WDATA
);

    state_t                  state_reg;
    state_t                  state_next;
    logic [AXI_IDS_BITS-1:0] id_reg;
    logic                    aw_fire;
    logic                    w_fire;
    logic                    beat_last;
    logic [MEM_AW-1:0]       word_addr;
    logic                    resp_err;
    logic                    we_block;

    assign aw_fire = AWVALID && AWREADY;
    assign w_fire  = WVALID && WREADY;

    axi_burst_addr #(
        .MEM_AW(MEM_AW)
    ) u_burst_addr (
        .clk       (ACLK),
        .rst       (ARESET),
        .load      (aw_fire),
        .step      (w_fire),
        .start_addr(AWADDR[MEM_AW+1:2]),
        .len       (AWLEN),
        .burst     (AWBURST),
        .addr      (word_addr),
        .last      (beat_last)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_reg <= ST_IDLE;
            id_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (aw_fire) begin
                id_reg <= AWID;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        AWREADY    = 1'b0;
        WREADY     = 1'b0;
        BVALID     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                AWREADY = 1'b1;
                if (AWVALID) state_next = ST_DATA;
            end
            ST_DATA: begin
                WREADY = 1'b1;
                // Whichever comes first ends the burst: WLAST or the final counted beat
                if (WVALID && (WLAST || beat_last)) state_next = ST_RESP;
            end
            ST_RESP: begin
                BVALID = 1'b1;
                if (BREADY) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

`ifdef AXI_SLV_WR_CHECK_EN
    logic resp_err_reg;
    logic we_block_reg;
    logic cfg_err;

    assign cfg_err = (AWSIZE != SIZE_WORD) || AWBURST[1];

    // Configuration errors block every write of the burst; WLAST misplacement only flags the response
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            resp_err_reg <= 1'b0;
            we_block_reg <= 1'b0;
        end else if (aw_fire) begin
            resp_err_reg <= cfg_err;
            we_block_reg <= cfg_err;
        end else if (w_fire && (WLAST != beat_last)) begin
            resp_err_reg <= 1'b1;
        end
    end

    assign resp_err = resp_err_reg;
    assign we_block = we_block_reg;
`else
    logic unused_size;
    assign unused_size = ^AWSIZE;
    assign resp_err    = 1'b0;
    assign we_block    = 1'b0;
`endif

    logic unused_addr_bits;
    assign unused_addr_bits = ^{AWADDR[AXI_ADDR_BITS-1:MEM_AW+2], AWADDR[1:0]};

    assign BID       = id_reg;
    assign BRESP     = resp_err ? RESP_SLVERR : RESP_OKAY;
    assign MEM_WE    = (w_fire && !we_block) ? WSTRB : '0;
    assign MEM_ADDR  = word_addr;
    assign MEM_WDATA = w_fire ? WDATA : '0;

endmodule

// File: doc/axi_slave_write_resp.md
AXI_SLAVE_WRITE_RESP -- requirements
Module: axi_slave_write_resp

Interface
REQ-001 Parameter MEM_AW, default 14: memory word-address width.
REQ-002 ACLK  in  1  sole clock; all state updates on rising edge.
REQ-003 ARESET  in  1  reset, asynchronous, active-high.
REQ-004 AWID  in  AXI_IDS_BITS(8)  write transaction ID.
REQ-005 AWADDR  in  32  burst start byte address.
REQ-006 AWLEN  in  4  beats minus one.
REQ-007 AWSIZE  in  3  bytes per beat, log2.
REQ-008 AWBURST  in  2  burst type.
REQ-009 AWVALID  in  1  address valid.
REQ-010 AWREADY  out  1  address accepted.
REQ-011 WDATA  in  32  write data.
REQ-012 WSTRB  in  4  byte strobes.
REQ-013 WLAST  in  1  final beat marker.
REQ-014 WVALID  in  1  data valid.
REQ-015 WREADY  out  1  data accepted.
REQ-016 BID  out  AXI_IDS_BITS(8)  response ID.
REQ-017 BRESP  out  2  response code.
REQ-018 BVALID  out  1  response valid.
REQ-019 BREADY  in  1  response accepted.
REQ-020 MEM_WE  out  4  per-byte write enable, active-high.
REQ-021 MEM_ADDR  out  MEM_AW  memory word address.
REQ-022 MEM_WDATA  out  32  memory write data.

Function
REQ-023 Three-state FSM: IDLE, DATA, RESP; state held in a register.
REQ-024 IDLE: AWREADY=1; on AWVALID&&AWREADY capture AWID, AWADDR[MEM_AW+1:2], AWLEN, AWBURST, AWSIZE; beat counter cleared; go to DATA next cycle.
REQ-025 DATA: WREADY=1; each WVALID&&WREADY drives MEM_WE=WSTRB, MEM_WDATA=WDATA, MEM_ADDR=current word address, same cycle (zero latency); MEM_WE=0 otherwise.
REQ-026 Address update per beat: INCR (01) adds 1 modulo 2^MEM_AW; FIXED (00) holds; WRAP (10) and reserved (11) treated as INCR.
REQ-027 DATA exits to RESP on a W handshake with WLAST=1 or beat counter==AWLEN, whichever first.
REQ-028 RESP: BVALID=1, BID=captured AWID, BRESP per REQ-033; on BVALID&&BREADY go to IDLE; BID/BRESP stable while BVALID=1 and BREADY=0.
REQ-029 BVALID rises the cycle after the last W handshake; next AWREADY the cycle after the B handshake; no AW/W overlap, one outstanding transaction.
REQ-030 AWREADY, WREADY, BVALID mutually exclusive; MEM_WE nonzero only in DATA.

Reset
REQ-031 ARESET forces IDLE immediately: AWREADY=1, WREADY=0, BVALID=0, BID=0, BRESP=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, counter=0.
REQ-032 Reset mid-burst or mid-response discards the transaction; no B issued for it.

Configuration
REQ-033 Macro AXI_SLV_WR_CHECK_EN defined: BRESP=SLVERR (10) if AWSIZE!=2, AWBURST is WRAP/reserved, WLAST=1 before beat AWLEN, or WLAST=0 at beat AWLEN; MEM_WE forced 0 for AWSIZE/AWBURST errors; else OKAY (00). Undefined: BRESP always OKAY, no checks, every beat written.

Structure
REQ-034 Shared header/package holds AXI_IDS_BITS, AXI_ADDR_BITS, AXI_DATA_BITS, AXI_STRB_BITS, AXI_LEN_BITS, BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR, FSM state enum.
REQ-035 One sub-module axi_burst_addr: holds word address and beat counter, load/step/last outputs.

Verification
REQ-036 AWID=8'h15, AWADDR=0x100, AWLEN=3, INCR, 4 beats WSTRB=F, WLAST on beat 4 -> MEM_ADDR 0x40..0x43, BVALID next cycle, BID=8'h15, BRESP=00.
REQ-037 FIXED, AWADDR=0x20, AWLEN=1, WSTRB=4'b0011 -> both writes at MEM_ADDR 0x08, MEM_WE=0011.
REQ-038 BREADY held 0 for 5 cycles -> BVALID, BID, BRESP stable; AWREADY=0 throughout; IDLE after handshake.
REQ-039 AXI_SLV_WR_CHECK_EN, AWLEN=3, WLAST on beat 2 -> RESP after beat 2, BRESP=10; AWSIZE=1 -> MEM_WE=0, BRESP=10; without macro both give BRESP=00.
REQ-040 ARESET asserted after beat 2 of AWLEN=3 -> same cycle IDLE, MEM_WE=0, BVALID=0; new AW accepted after release.
REQ-041 INCR from word 0x3FFF (MEM_AW=14), AWLEN=1 -> second write at MEM_ADDR 0x0000.
